dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that acts as the initiator for the data-memory port. It accepts one CPU load or store request at a time via a valid/ready handshake and drives mem_read/mem_write/mem_addr/mem_wdata into the word-wide data memory. It returns sign- or zero-extended byte, half and word loads. Sub-word stores are done as read-modify-write, because the memory has no byte enables. The unit sits between the CPU execute stage and the data memory.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; only 32 is supported
- BASE_ADDR, 32'h0001_0000, first byte address of the data memory
- MEM_DEPTH, 1024, memory depth in words
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit can accept; 1 only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads when 1
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: range, alignment or size error
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned byte address (low 2 bits 0)
- mem_wdata  out  DATA_WIDTH  full-word write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the mem_read edge

## Operation
- Accept on the clk edge where req_valid && req_ready. Latch all request fields. mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}, held until the next accept.
- Range check: BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH. Compute it in ADDR_WIDTH+1 bits so the upper bound cannot wrap.
- Error if out of range, if req_size == 11, or if misaligned (see Configuration). On error: no mem strobe; next state is RESP with rsp_err=1.
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE → RD for a load or a sub-word store.
  - IDLE → WR for a word store.
  - IDLE → RESP on error.
  - RD → CAP.
  - CAP → RESP for a load; CAP → WR for a store.
  - WR → RESP.
  - RESP → IDLE.
- mem_read = 1 only in RD. mem_write = 1 only in WR. They are never both 1.
- CAP samples mem_rdata:
  - Load: extract the lane (byte k = addr[1:0], half = addr[1]), then sign-extend, or zero-extend if req_unsigned.
  - Store: merge req_wdata[7:0] or [15:0] into the lane and leave the other bytes unchanged. The merged word drives mem_wdata in WR.
- Word store: mem_wdata = req_wdata.
- Requests presented while req_ready=0 are ignored and not queued.
- rsp_valid has no backpressure.

## Timing
- Reset values: req_ready=1. All other outputs 0. FSM in IDLE.
- Accept edge = E0. Load: mem_read in cycle 1, CAP in cycle 2, rsp_valid in cycle 3.
- Word store: mem_write in cycle 1, rsp_valid in cycle 2.
- Sub-word store: mem_read in cycle 1, CAP in cycle 2, mem_write in cycle 3, rsp_valid in cycle 4.
- Error: rsp_valid in cycle 1.
- req_ready rises in the cycle after RESP. Back-to-back word stores therefore complete one every 3 cycles.
- Reset mid-operation: asynchronously clears mem_read, mem_write, rsp_valid and the FSM. The in-flight access is abandoned and no response is issued.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with addr[1:0]≠0, gives rsp_err=1 and no memory access.
- Undefined: misalignment is not an error. The address is truncated to natural alignment (half: addr[0] ignored; word: addr[1:0] ignored).

## Test plan
- Word store 0xDEADBEEF to 0x0001_0010, then word load 0x0001_0010 → mem_write pulse with mem_addr 0x0001_0010; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
- Byte store 0xAA to 0x0001_0011 over word 0xDEADBEEF → RD, then WR with mem_wdata=0xDEADAAEF. Signed byte load from 0x0001_0011 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half store 0x1234 to 0x0001_0012, then signed half load → word 0x1234AAEF; rsp_rdata=0x00001234.
- Load 0x0000_FFFC, load 0x0001_1000, and req_size=11 → rsp_err=1 in cycle 1, mem_read/mem_write never asserted.
- Word load 0x0001_0002 → with LSU_MISALIGN_TRAP_EN: rsp_err=1 and no strobe; without: mem_addr=0x0001_0000, data returned.
- Assert reset_n=0 during CAP of a sub-word store → mem_write never asserted, memory word unchanged; after release req_ready=1 and rsp_valid=0.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: CPU request/response channel and word-wide data-memory port of dmem_lsu.
// master = the load/store unit, slave = the CPU/memory side.
interface dmem_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err.
module dmem_lsu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_0000,
    parameter int                    MEM_DEPTH  = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    dmem_lsu_if.master bus
);
    localparam logic [ADDR_WIDTH:0] LP_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LP_HI = LP_LO + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_lane;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_addr_ext;
    logic                  w_misalign;
    logic                  w_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_addr_ext = {1'b0, bus.req_addr};

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (w_addr_ext < LP_LO) || (w_addr_ext >= LP_HI) ||
                   (bus.req_size == 2'b11) || w_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)                                       w_next = ST_RESP;
                    else if (bus.req_we && (bus.req_size == 2'b10))  w_next = ST_WR;
                    else                                             w_next = ST_RD;
                end
            end
            ST_RD:   w_next = ST_CAP;
            ST_CAP:  w_next = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Lane select: half uses only addr[1], so an unaligned half is truncated when not trapped.
    always_comb begin
        w_byte = bus.mem_rdata[8*r_lane +: 8];
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{!r_unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{!r_unsigned && w_half[15]}}, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    // r_mem_wdata still holds the right-aligned store data until CAP overwrites it.
    always_comb begin
        w_merged = bus.mem_rdata;
        if (r_size == 2'b00) begin
            w_merged[8*r_lane +: 8] = r_mem_wdata[7:0];
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_mem_wdata[15:0];
        end else begin
            w_merged[15:0] = r_mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we        <= 1'b0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_lane      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_unsigned  <= bus.req_unsigned;
            r_lane      <= bus.req_addr[1:0];
            r_err       <= w_err;
            r_rdata     <= '0;
            r_mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            r_mem_wdata <= bus.req_wdata;
        end else if (r_state == ST_CAP) begin
            if (r_we) r_mem_wdata <= w_merged;
            else      r_rdata     <= w_load;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.mem_read  = (r_state == ST_RD);
    assign bus.mem_write = (r_state == ST_WR);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_err   = (r_state == ST_RESP) && r_err;
    assign bus.rsp_rdata = (r_state == ST_RESP) ? r_rdata : '0;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed load/store vectors for dmem_lsu with queued expectations
// checked by independent response and memory-strobe monitors.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cnt = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    dmem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_lsu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (32'h0001_0000),
        .MEM_DEPTH (1024)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Word-wide data memory: read data valid one cycle after the mem_read edge.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[11:2]];
        if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          id;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    rsp_t    rq[$];
    strobe_t sq[$];

    function automatic void chk(input string name, input int id, input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (req %0d): actual=%h required=%h", name, id, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        if (bus.rsp_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", -1, 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk("rsp_rdata", e.id, bus.rsp_rdata, e.rdata);
                chk("rsp_err",   e.id, 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_cycle", e.id, 32'(cnt), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        strobe_t s;
        if (bus.mem_read && bus.mem_write) chk("both_strobes", -1, 32'd1, 32'd0);
        if (bus.mem_read || bus.mem_write) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", -1, {bus.mem_write, bus.mem_addr[30:0]}, 32'd0);
            end else begin
                s = sq.pop_front();
                chk("strobe_kind", -1, 32'(bus.mem_write), 32'(s.wr));
                chk("mem_addr",    -1, bus.mem_addr, s.addr);
                if (s.wr) chk("mem_wdata", -1, bus.mem_wdata, s.wdata);
            end
        end
    end

    task automatic exp_rd(input logic [31:0] a);
        sq.push_back('{1'b0, a, 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        sq.push_back('{1'b1, a, d});
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) chk("ready_timeout", -1, 32'(bus.req_ready), 32'd1);
    endtask

    // Called at a negedge; a different request is held during the first busy cycle and must be ignored.
    task automatic issue(input int id, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd_data, input logic exp_err, input int lat);
        wait_ready();
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        rq.push_back('{exp_rd_data, exp_err, cnt + lat, id});
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0001_0020;
        bus.req_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_rdata    = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 0, 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 0, 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err",   0, 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_rdata", 0, bus.rsp_rdata, 32'd0);
        chk("reset_strobes",   0, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("reset_mem_addr",  0, bus.mem_addr, 32'd0);
        chk("reset_mem_wdata", 0, bus.mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        exp_wr(32'h0001_0010, 32'hDEAD_BEEF);
        issue(1, 1'b1, 2'b10, 1'b0, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        exp_rd(32'h0001_0010);
        issue(2, 1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

        exp_rd(32'h0001_0010);
        exp_wr(32'h0001_0010, 32'hDEAD_AAEF);
        issue(3, 1'b1, 2'b00, 1'b0, 32'h0001_0011, 32'h1234_56AA, 32'h0, 1'b0, 4);
        exp_rd(32'h0001_0010);
        issue(4, 1'b0, 2'b00, 1'b0, 32'h0001_0011, 32'h0, 32'hFFFF_FFAA, 1'b0, 3);
        exp_rd(32'h0001_0010);
        issue(5, 1'b0, 2'b00, 1'b1, 32'h0001_0011, 32'h0, 32'h0000_00AA, 1'b0, 3);

        exp_rd(32'h0001_0010);
        exp_wr(32'h0001_0010, 32'h1234_AAEF);
        issue(6, 1'b1, 2'b01, 1'b0, 32'h0001_0012, 32'hABCD_1234, 32'h0, 1'b0, 4);
        exp_rd(32'h0001_0010);
        issue(7, 1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, 32'h1234_AAEF, 1'b0, 3);
        exp_rd(32'h0001_0010);
        issue(8, 1'b0, 2'b01, 1'b0, 32'h0001_0012, 32'h0, 32'h0000_1234, 1'b0, 3);
        exp_rd(32'h0001_0010);
        issue(9, 1'b0, 2'b01, 1'b0, 32'h0001_0010, 32'h0, 32'hFFFF_AAEF, 1'b0, 3);
        exp_rd(32'h0001_0010);
        issue(10, 1'b0, 2'b00, 1'b0, 32'h0001_0010, 32'h0, 32'hFFFF_FFEF, 1'b0, 3);
        exp_rd(32'h0001_0010);
        issue(11, 1'b0, 2'b00, 1'b1, 32'h0001_0013, 32'h0, 32'h0000_0012, 1'b0, 3);

        exp_wr(32'h0001_0FFC, 32'hCAFE_F00D);
        issue(12, 1'b1, 2'b10, 1'b0, 32'h0001_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        exp_rd(32'h0001_0FFC);
        issue(13, 1'b0, 2'b10, 1'b0, 32'h0001_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

        issue(14, 1'b0, 2'b10, 1'b0, 32'h0000_FFFC, 32'h0, 32'h0, 1'b1, 1);
        issue(15, 1'b0, 2'b10, 1'b0, 32'h0001_1000, 32'h0, 32'h0, 1'b1, 1);
        issue(16, 1'b0, 2'b11, 1'b0, 32'h0001_0010, 32'h0, 32'h0, 1'b1, 1);
        issue(17, 1'b1, 2'b11, 1'b0, 32'h0001_0010, 32'h5555_5555, 32'h0, 1'b1, 1);
        issue(18, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0, 1'b1, 1);

        exp_wr(32'h0001_0000, 32'h1122_3344);
        issue(19, 1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'h1122_3344, 32'h0, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(20, 1'b0, 2'b10, 1'b0, 32'h0001_0002, 32'h0, 32'h0, 1'b1, 1);
`else
        exp_rd(32'h0001_0000);
        issue(20, 1'b0, 2'b10, 1'b0, 32'h0001_0002, 32'h0, 32'h1122_3344, 1'b0, 3);
`endif

        // Reset lands while a sub-word store is in CAP: read happens, write must not.
        wait_ready();
        exp_rd(32'h0001_0010);
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0001_0010;
        bus.req_wdata    = 32'h0000_0055;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", 21, 32'(bus.req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 21, 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_strobes",   21, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_post_req_ready", 21, 32'(bus.req_ready), 32'd1);
        chk("rst_post_rsp_valid", 21, 32'(bus.rsp_valid), 32'd0);
        exp_rd(32'h0001_0010);
        issue(22, 1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, 32'h1234_AAEF, 1'b0, 3);

        wait_ready();
        repeat (4) @(negedge clk);
        chk("rsp_queue_drained",    -1, 32'(rq.size()), 32'd0);
        chk("strobe_queue_drained", -1, 32'(sq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
